// File: rtl/load_store_unit.sv
// Load/store unit: one memory op at a time, req/ack handshake with data memory,
// load alignment/extension and register-file writeback.
module load_store_unit (
    input  logic        clk,
    input  logic        async_reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic        fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned BE_W   = 4;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WB   = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    logic [1:0]        state,     state_n;
    logic              op_store,  op_store_n;
    logic [2:0]        op_funct3, op_funct3_n;
    logic [1:0]        op_lo,     op_lo_n;
    logic [REG_W-1:0]  op_rd,     op_rd_n;

    logic              busy_n, done_n, fault_n, mem_req_n, mem_we_n, rf_we_n;
    logic [DATA_W-1:0] mem_addr_n, mem_wdata_n, rf_wdata_n;
    logic [BE_W-1:0]   mem_be_n;
    logic [REG_W-1:0]  rf_waddr_n;

    // Alignment and funct3 legality for the access being launched.
    function automatic logic legal_access(input logic st, input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic ok;
        case (f3)
            3'b000:  ok = 1'b1;
            3'b001:  ok = (lo[0] == 1'b0);
            3'b010:  ok = (lo == 2'b00);
            3'b100:  ok = !st;
            3'b101:  ok = !st && (lo[0] == 1'b0);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [BE_W-1:0] byte_mask(input logic [1:0] size, input logic [1:0] lo);
        logic [BE_W-1:0] m;
        case (size)
            2'b00:   m = BE_W'(4'b0001 << lo);
            2'b01:   m = BE_W'(4'b0011 << lo);
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] store_lanes(input logic [1:0] size,
                                                      input logic [DATA_W-1:0] sd);
        logic [DATA_W-1:0] w;
        case (size)
            2'b00:   w = {4{sd[7:0]}};
            2'b01:   w = {2{sd[15:0]}};
            default: w = sd;
        endcase
        return w;
    endfunction

    // Shift the addressed lane down to bit 0, then extend by access type.
    function automatic logic [DATA_W-1:0] extract(input logic [2:0] f3, input logic [1:0] lo,
                                                  input logic [DATA_W-1:0] rdata);
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] r;
        s = rdata >> {lo, 3'b000};
        case (f3)
            3'b000:  r = {{24{s[7]}}, s[7:0]};
            3'b001:  r = {{16{s[15]}}, s[15:0]};
            3'b100:  r = {24'd0, s[7:0]};
            3'b101:  r = {16'd0, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        op_store_n  = op_store;
        op_funct3_n = op_funct3;
        op_lo_n     = op_lo;
        op_rd_n     = op_rd;
        done_n      = 1'b0;
        fault_n     = 1'b0;
        rf_we_n     = 1'b0;
        mem_req_n   = mem_req;
        mem_we_n    = mem_we;
        mem_addr_n  = mem_addr;
        mem_be_n    = mem_be;
        mem_wdata_n = mem_wdata;
        rf_waddr_n  = rf_waddr;
        rf_wdata_n  = rf_wdata;

        case (state)
            S_IDLE: begin
                if (start) begin
                    op_store_n  = is_store;
                    op_funct3_n = funct3;
                    op_lo_n     = addr[1:0];
                    op_rd_n     = rd;
                    if (legal_access(is_store, funct3, addr[1:0])) begin
                        state_n     = S_REQ;
                        mem_req_n   = 1'b1;
                        mem_we_n    = is_store;
                        mem_addr_n  = {addr[31:2], 2'b00};
                        mem_be_n    = byte_mask(funct3[1:0], addr[1:0]);
                        mem_wdata_n = store_lanes(funct3[1:0], store_data);
                    end else begin
                        state_n = S_ERR;
                        done_n  = 1'b1;
                        fault_n = 1'b1;
                    end
                end
            end
            S_REQ: begin
                if (mem_ack) begin
                    state_n   = S_WB;
                    mem_req_n = 1'b0;
                    done_n    = 1'b1;
                    if (!op_store) begin
                        rf_we_n    = (op_rd != '0);
                        rf_waddr_n = op_rd;
                        rf_wdata_n = extract(op_funct3, op_lo, mem_rdata);
                    end
                end
            end
            S_WB:    state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk or negedge async_reset) begin
        if (!async_reset) begin
            state     <= S_IDLE;
            op_store  <= 1'b0;
            op_funct3 <= '0;
            op_lo     <= '0;
            op_rd     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
        end else begin
            state     <= state_n;
            op_store  <= op_store_n;
            op_funct3 <= op_funct3_n;
            op_lo     <= op_lo_n;
            op_rd     <= op_rd_n;
            busy      <= busy_n;
            done      <= done_n;
            fault     <= fault_n;
            mem_req   <= mem_req_n;
            mem_we    <= mem_we_n;
            mem_addr  <= mem_addr_n;
            mem_be    <= mem_be_n;
            mem_wdata <= mem_wdata_n;
            rf_we     <= rf_we_n;
            rf_waddr  <= rf_waddr_n;
            rf_wdata  <= rf_wdata_n;
        end
    end

endmodule
